ip_bwd_sched: RTL and testbench

Sequencer for the inner-product backward datapath. Walks a layer of cfg_rows output neurons x cfg_chunks WIDTH-wide input chunks, and issues data and weight memory reads. It drives the datapath's 8-bit id field in step with the read data. Returned ids are matched in order, each partial dot product is labelled with its row and chunk for the downstream accumulator, and issue is limited by a credit count supplied by that accumulator.

---
 rtl/ip_bwd_sched.sv | 173 +++++++++++++++++
 tb/tb_ip_bwd_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_bwd_sched.sv
// Issue sequencer for the inner-product backward datapath.
// Walks rows x chunks, issues data/weight reads under accumulator credit
// control, tags each read with a 7-bit sequence id that travels with the read
// data, and labels returned partial products with their row and chunk.
//
// Handshake: an issue happens in any cycle where rd_en=1 (no back-pressure
// from memory); a return is taken in any RUN/DRAIN cycle where ret_id[7]=1;
// a credit comes back in any cycle where cred_ret=1.
module ip_bwd_sched #(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int CREDITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_rows,
  input  logic [ADDR_W-1:0] cfg_chunks,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [7:0]        dp_id,
  input  logic [7:0]        ret_id,
  input  logic              cred_ret,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_row,
  output logic [ADDR_W-1:0] res_chunk,
  output logic              res_last,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t            state, state_nx;
  logic [7:0]        credits;
  logic [ADDR_W-1:0] rows_q, chunks_q;
  logic [ADDR_W-1:0] iss_row, iss_chunk, wt_cnt;
  logic [ADDR_W-1:0] ret_row, ret_chunk;
  logic [6:0]        tag, exp_tag;
  logic              ret_done;
  logic [7:0]        dly [MEM_LAT];

  logic accept, issue, chunk_wrap, iss_last;
  logic ret_fire, ret_wrap, ret_is_last;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (cfg_rows == '0 || cfg_chunks == '0) ? S_FIN : S_RUN;
      S_RUN:   if (iss_last) state_nx = S_DRAIN;
      S_DRAIN: if (ret_done || (ret_fire && ret_is_last)) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    accept      = (state == S_IDLE) && start;
    issue       = (state == S_RUN) && (credits != 8'd0);
    chunk_wrap  = (iss_chunk == chunks_q - ADDR_W'(1));
    iss_last    = issue && chunk_wrap && (iss_row == rows_q - ADDR_W'(1));
    ret_fire    = ret_id[7] && (state == S_RUN || state == S_DRAIN);
    ret_wrap    = (ret_chunk == chunks_q - ADDR_W'(1));
    ret_is_last = ret_wrap && (ret_row == rows_q - ADDR_W'(1));
    busy        = (state != S_IDLE);
    rd_en       = issue;
    data_addr   = iss_chunk;
    wt_addr     = wt_cnt;
    dp_id       = dly[MEM_LAT-1];
  end

  // Config latch and issue-side counters; wt_addr is a running count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q    <= '0;
      chunks_q  <= '0;
      iss_row   <= '0;
      iss_chunk <= '0;
      wt_cnt    <= '0;
      tag       <= '0;
    end else if (accept) begin
      rows_q    <= cfg_rows;
      chunks_q  <= cfg_chunks;
      iss_row   <= '0;
      iss_chunk <= '0;
      wt_cnt    <= '0;
      tag       <= '0;
    end else if (issue) begin
      if (chunk_wrap) begin
        iss_chunk <= '0;
        iss_row   <= iss_row + ADDR_W'(1);
      end else begin
        iss_chunk <= iss_chunk + ADDR_W'(1);
      end
      wt_cnt <= wt_cnt + ADDR_W'(1);
      tag    <= tag + 7'd1;
    end
  end

  // Credit pool: issue takes one, cred_ret gives one back, never above CREDITS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= 8'(CREDITS);
    end else if (issue && !cred_ret) begin
      credits <= credits - 8'd1;
    end else if (!issue && cred_ret && credits < 8'(CREDITS)) begin
      credits <= credits + 8'd1;
    end
  end

  // Id delay line so dp_id lines up with the memory read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {issue, tag};
      for (int i = 1; i < MEM_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Return side: label results in issue order and check the sequence tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_row   <= '0;
      res_chunk <= '0;
      res_last  <= 1'b0;
      ret_row   <= '0;
      ret_chunk <= '0;
      exp_tag   <= '0;
      ret_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      res_valid <= ret_fire;
      if (accept) begin
        ret_row   <= '0;
        ret_chunk <= '0;
        exp_tag   <= '0;
        ret_done  <= 1'b0;
      end else if (ret_fire) begin
        res_row   <= ret_row;
        res_chunk <= ret_chunk;
        res_last  <= ret_wrap;
        if (ret_wrap) begin
          ret_chunk <= '0;
          ret_row   <= ret_row + ADDR_W'(1);
        end else begin
          ret_chunk <= ret_chunk + ADDR_W'(1);
        end
        exp_tag <= exp_tag + 7'd1;
        if (ret_is_last) ret_done <= 1'b1;
        if (ret_id[6:0] != exp_tag) err <= 1'b1;
      end
    end
  end

  // Done pulse trails the FIN cycle so it never overlaps busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == S_FIN);
  end

endmodule

// File: tb/tb_ip_bwd_sched.sv
// Randomized bench for ip_bwd_sched: a datapath model echoes dp_id back as
// ret_id, an accumulator model returns credits, and a monitor compares every
// issue, id and result against queues filled from a row/chunk reference walk.
module tb_ip_bwd_sched;
  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 2;
  localparam int CREDITS = 8;
  localparam int DP_LAT  = 2;
  localparam int TIMEOUT = 5000;

  logic              clk, reset, start, rd_en, busy, done, cred_ret;
  logic [ADDR_W-1:0] cfg_rows, cfg_chunks, data_addr, wt_addr, res_row, res_chunk;
  logic [7:0]        dp_id, ret_id;
  logic              res_valid, res_last, err;

  ip_bwd_sched #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .CREDITS(CREDITS)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows),
    .cfg_chunks(cfg_chunks), .busy(busy), .done(done), .rd_en(rd_en),
    .data_addr(data_addr), .wt_addr(wt_addr), .dp_id(dp_id), .ret_id(ret_id),
    .cred_ret(cred_ret), .res_valid(res_valid), .res_row(res_row),
    .res_chunk(res_chunk), .res_last(res_last), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_iss_q[$];
  logic [7:0]  exp_dp_q[$];
  logic [32:0] exp_res_q[$];
  int   cyc = 0, pass_iss = 0, first_iss = -1, last_iss = 0;
  int   done_cnt = 0, pass_done0 = 0;
  int   model_cred = CREDITS;
  bit   err_model = 0;
  logic [7:0] hist = '0;
  bit   auto_cred = 1, manual_cred = 0, bad_now = 0;
  int   corrupt_at = -1, ret_idx = 0;
  logic [7:0] pipe [DP_LAT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- datapath model: echo dp_id after DP_LAT-1 cycles ----------------
  initial begin
    ret_id = '0;
    for (int i = 0; i < DP_LAT; i++) pipe[i] = '0;
    forever begin
      @(posedge clk); #1;
      bad_now = 0;
      if (reset) begin
        for (int i = 0; i < DP_LAT; i++) pipe[i] = '0;
        ret_id = '0;
      end else begin
        for (int i = DP_LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = dp_id;
        ret_id  = pipe[DP_LAT-1];
        if (ret_id[7]) begin
          if (ret_idx == corrupt_at) begin
            ret_id[6:0] = ret_id[6:0] + 7'd1;
            bad_now = 1;
          end
          ret_idx++;
        end
      end
    end
  end

  // ---------------- accumulator model: credit returns ----------------
  initial begin
    cred_ret = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset)          cred_ret = 1'b0;
      else if (auto_cred) cred_ret = (model_cred < CREDITS) && ($urandom_range(0, 3) != 0);
      else                cred_ret = manual_cred;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] ei;
    logic [7:0]  ed;
    logic [32:0] er;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) continue;
      if (rd_en) begin
        pass_iss++;
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        if (exp_iss_q.size() == 0) chk("unexpected_rd_en", 64'(rd_en), 64'd0);
        else begin
          ei = exp_iss_q.pop_front();
          chk("issue_addr", 64'({data_addr, wt_addr}), 64'(ei));
        end
      end
      if (model_cred == 0) chk("credit_gate", 64'(rd_en), 64'd0);
      if (rd_en && !cred_ret) model_cred--;
      else if (!rd_en && cred_ret && model_cred < CREDITS) model_cred++;
      if (dp_id[7] || hist[MEM_LAT-1]) chk("dp_id_latency", 64'(dp_id[7]), 64'(hist[MEM_LAT-1]));
      hist = {hist[6:0], rd_en};
      if (dp_id[7]) begin
        if (exp_dp_q.size() == 0) chk("unexpected_dp_id", 64'(dp_id), 64'd0);
        else begin
          ed = exp_dp_q.pop_front();
          chk("dp_id", 64'(dp_id), 64'(ed));
        end
      end
      if (res_valid) begin
        if (exp_res_q.size() == 0) chk("unexpected_res", 64'(res_valid), 64'd0);
        else begin
          er = exp_res_q.pop_front();
          chk("result_label", 64'({res_row, res_chunk, res_last}), 64'(er));
        end
      end
      if (res_valid || done) chk("err_flag", 64'(err), 64'(err_model));
      if (ret_id[7] && bad_now) err_model = 1;
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Reference walk: every (row, chunk) in row-major order, one tag per issue.
  task automatic begin_pass(input int rows, input int chunks);
    int idx = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < chunks; c++) begin
        exp_iss_q.push_back({16'(c), 16'(r * chunks + c)});
        exp_dp_q.push_back({1'b1, 7'(idx % 128)});
        exp_res_q.push_back({16'(r), 16'(c), (c == chunks - 1)});
        idx++;
      end
    pass_iss = 0; first_iss = -1; ret_idx = 0; pass_done0 = done_cnt;
    @(negedge clk);
    start = 1'b1; cfg_rows = 16'(rows); cfg_chunks = 16'(chunks);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_pass(input string name);
    int t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (!done && t < TIMEOUT);
    if (!done) chk({name, "_done_timeout"}, 64'(done), 64'd1);
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({name, "_all_results_seen"}, 64'(exp_res_q.size() + exp_dp_q.size() + exp_iss_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    #1 chk({name, "_single_done"}, 64'(done_cnt), 64'(pass_done0 + 1));
  endtask

  task automatic zero_pass(input int rows, input int chunks, input string name);
    int d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; cfg_rows = 16'(rows); cfg_chunks = 16'(chunks);
    @(negedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_c1"}, 64'({busy, done}), 64'b10);
    @(negedge clk); #1;
    chk({name, "_done_c2"}, 64'({busy, done}), 64'b01);
    @(negedge clk); #1;
    chk({name, "_done_once"}, 64'({done, 16'(done_cnt)}), 64'({1'b0, 16'(d0 + 1)}));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctrl"}, 64'({busy, done, rd_en, res_valid, res_last, err, dp_id}), 64'd0);
    chk({name, "_addr"}, {data_addr, wt_addr, res_row, res_chunk}, 64'd0);
  endtask

  task automatic wait_credits_full();
    int t = 0;
    while (model_cred != CREDITS && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    chk("credits_refilled", 64'(model_cred), 64'(CREDITS));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; cfg_rows = '0; cfg_chunks = '0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // basic 2x3 pass, back-to-back issues from a full credit pool
    begin_pass(2, 3);
    finish_pass("p2x3");
    chk("p2x3_consecutive", 64'(last_iss - first_iss), 64'd5);
    chk("p2x3_err", 64'(err), 64'd0);

    // start while busy must be ignored
    begin_pass(3, 4);
    repeat (3) @(negedge clk);
    start = 1'b1; cfg_rows = 16'd1; cfg_chunks = 16'd1;
    @(negedge clk);
    start = 1'b0;
    finish_pass("p3x4_busy_start");

    // empty configurations
    zero_pass(0, 3, "rows0");
    zero_pass(2, 0, "chunks0");

    // credit limiting
    wait_credits_full();
    auto_cred = 0;
    manual_cred = 1;
    repeat (3) @(negedge clk);
    manual_cred = 0;
    repeat (2) @(negedge clk);
    begin_pass(1, 12);
    repeat (20) @(negedge clk);
    #1 chk("cred_stall_issues", 64'(pass_iss), 64'(CREDITS));
    chk("cred_stall_rd_en", 64'(rd_en), 64'd0);
    manual_cred = 1;
    @(negedge clk);
    manual_cred = 0;
    repeat (10) @(negedge clk);
    #1 chk("cred_one_return", 64'(pass_iss), 64'(CREDITS + 1));
    manual_cred = 1;
    repeat (2) @(negedge clk);
    manual_cred = 0;
    repeat (10) @(negedge clk);
    #1 chk("cred_return_with_issue", 64'(pass_iss), 64'(CREDITS + 3));
    auto_cred = 1;
    finish_pass("p1x12_cred");

    // random shapes
    for (int k = 0; k < 4; k++) begin
      begin_pass($urandom_range(1, 4), $urandom_range(1, 6));
      finish_pass("rand");
    end

    // corrupted third return sets err; it stays set across passes
    corrupt_at = 2;
    begin_pass(2, 3);
    finish_pass("p_corrupt");
    chk("err_set", 64'(err), 64'd1);
    corrupt_at = -1;
    begin_pass(1, 4);
    finish_pass("p_after_err");
    chk("err_sticky", 64'(err), 64'd1);

    // reset mid-RUN after three issues
    begin_pass(2, 3);
    begin
      int t = 0;
      while (pass_iss < 3 && t < 200) begin
        @(negedge clk); #1;
        t++;
      end
    end
    chk("reached_three_issues", 64'(pass_iss), 64'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 check_all_zero("mid_reset");
    exp_iss_q.delete(); exp_dp_q.delete(); exp_res_q.delete();
    err_model = 0; model_cred = CREDITS; hist = '0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("no_done_after_abort", 64'(done_cnt), 64'(d0));
    begin_pass(2, 3);
    finish_pass("p_after_reset");

    // tag wrap 0x7F -> 0x00
    begin_pass(1, 200);
    finish_pass("p_wrap");
    chk("wrap_err", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
